// File: rtl/sensor_seq_pkg.sv
// Shared encodings for the gate-sensor sequence generator: commands, FSM states and the
// {a,b} beam patterns emitted in each phase.
package sensor_seq_pkg;

  localparam logic [1:0] CMD_ENTER      = 2'b00;
  localparam logic [1:0] CMD_EXIT       = 2'b01;
  localparam logic [1:0] CMD_BALK_ENTER = 2'b10;
  localparam logic [1:0] CMD_BALK_EXIT  = 2'b11;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] PH1  = 3'd1;
  localparam logic [2:0] PH2  = 3'd2;
  localparam logic [2:0] PH3  = 3'd3;
  localparam logic [2:0] GAP  = 3'd4;

  localparam logic [1:0] AB_CLEAR = 2'b00;
  localparam logic [1:0] AB_OUTER = 2'b10;
  localparam logic [1:0] AB_INNER = 2'b01;
  localparam logic [1:0] AB_BOTH  = 2'b11;

  // Car coming from the outside blocks a first; balks retreat the way they came.
  function automatic logic [1:0] phase_pattern(input logic [1:0] cmd, input logic [2:0] st);
    logic [1:0] pat;
    pat = AB_CLEAR;
    case (st)
      PH1: pat = (cmd == CMD_ENTER || cmd == CMD_BALK_ENTER) ? AB_OUTER : AB_INNER;
      PH2: pat = AB_BOTH;
      PH3: pat = (cmd == CMD_ENTER || cmd == CMD_BALK_EXIT) ? AB_INNER : AB_OUTER;
      default: pat = AB_CLEAR;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/sensor_seq_gen_if.sv
// Command handshake, beam outputs and completion tallies of the sensor sequence generator.
interface sensor_seq_gen_if #(
  parameter int unsigned CNT_W = 8
) ();
  logic             cmd_valid;
  logic [1:0]       cmd;
  logic             cmd_ready;
  logic             a;
  logic             b;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] enters_sent;
  logic [CNT_W-1:0] exits_sent;

  modport master (
    output cmd_valid, cmd,
    input  cmd_ready, a, b, busy, done, enters_sent, exits_sent
  );

  modport slave (
    input  cmd_valid, cmd,
    output cmd_ready, a, b, busy, done, enters_sent, exits_sent
  );
endinterface

// File: rtl/dwell_timer.sv
// Loadable down-counter: expired_o is high while the count sits at 1; it never goes below 1.
module dwell_timer #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q > W'(1)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= W'(1);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == W'(1));

endmodule

// File: rtl/sensor_seq_gen.sv
// Turns enter/exit/balk commands into timed two-beam sensor waveforms and tallies completed
// enters and exits.
module sensor_seq_gen
  import sensor_seq_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 4,
  parameter int unsigned GAP_CYCLES   = 3,
  parameter int unsigned CNT_W        = 8
) (
  input logic             clk,
  input logic             reset,
  sensor_seq_gen_if.slave bus
);

  localparam int unsigned MaxCyc = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
  localparam int unsigned TW     = $clog2(MaxCyc + 1);
  localparam logic [TW-1:0] DwellLd = TW'(DWELL_CYCLES);
  localparam logic [TW-1:0] GapLd   = TW'(GAP_CYCLES);

  logic [2:0]       state_q, state_d;
  logic [1:0]       cmd_q, cmd_d;
  logic [1:0]       ab_q, ab_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] enters_q, enters_d;
  logic [CNT_W-1:0] exits_q, exits_d;
  logic             tmr_load;
  logic [TW-1:0]    tmr_val;
  logic             tmr_exp;
  logic             cmd_ready;
  logic [2:0]       state_inc;

  assign cmd_ready = (state_q == IDLE) && !reset;
  assign state_inc = state_q + 3'd1;

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    ab_d     = ab_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    enters_d = enters_q;
    exits_d  = exits_q;
    tmr_load = 1'b0;
    tmr_val  = DwellLd;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready) begin
          cmd_d    = bus.cmd;
          state_d  = PH1;
          ab_d     = phase_pattern(bus.cmd, PH1);
          busy_d   = 1'b1;
          tmr_load = 1'b1;
        end
      end
      PH1, PH2: begin
        if (tmr_exp) begin
          state_d  = state_inc;
          ab_d     = phase_pattern(cmd_q, state_inc);
          tmr_load = 1'b1;
        end
      end
      PH3: begin
        if (tmr_exp) begin
          state_d  = GAP;
          ab_d     = AB_CLEAR;
          tmr_load = 1'b1;
          tmr_val  = GapLd;
        end
      end
      GAP: begin
        if (tmr_exp) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (cmd_q == CMD_ENTER) enters_d = enters_q + CNT_W'(1);
          if (cmd_q == CMD_EXIT)  exits_d  = exits_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        ab_d    = AB_CLEAR;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cmd_q    <= CMD_ENTER;
      ab_q     <= AB_CLEAR;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      enters_q <= '0;
      exits_q  <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      ab_q     <= ab_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      enters_q <= enters_d;
      exits_q  <= exits_d;
    end
  end

  dwell_timer #(
    .W (TW)
  ) u_dwell_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expired_o  (tmr_exp)
  );

  assign bus.cmd_ready   = cmd_ready;
  assign bus.a           = ab_q[1];
  assign bus.b           = ab_q[0];
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.enters_sent = enters_q;
  assign bus.exits_sent  = exits_q;

endmodule

// File: tb/tb_sensor_seq_gen.sv
// Directed bench for sensor_seq_gen: waveform timing, tallies, back-to-back, mid-sequence
// reset, and tally wrap on a narrow second instance.
module tb_sensor_seq_gen;

  localparam int unsigned D = 4;
  localparam int unsigned G = 3;
  localparam int unsigned SeqLen = 3 * D + G;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   exp_en = 0;
  int   exp_ex = 0;

  always #5 clk = ~clk;

  sensor_seq_gen_if #(.CNT_W(8)) bus ();
  sensor_seq_gen_if #(.CNT_W(2)) bus2 ();

  sensor_seq_gen #(
    .DWELL_CYCLES (D),
    .GAP_CYCLES   (G),
    .CNT_W        (8)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  sensor_seq_gen #(
    .DWELL_CYCLES (1),
    .GAP_CYCLES   (1),
    .CNT_W        (2)
  ) dut2 (
    .clk   (clk),
    .reset (rst),
    .bus   (bus2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called right after the accepting edge; returns in the done cycle.
  task automatic check_wave(input logic [1:0] p1, input logic [1:0] p3);
    logic [1:0] e;
    for (int j = 0; j < int'(SeqLen); j++) begin
      if (j < int'(D)) e = p1;
      else if (j < int'(2 * D)) e = 2'b11;
      else if (j < int'(3 * D)) e = p3;
      else e = 2'b00;
      chk("ab", {30'd0, bus.a, bus.b}, {30'd0, e});
      chk("busy", {31'd0, bus.busy}, 32'd1);
      chk("done_early", {31'd0, bus.done}, 32'd0);
      chk("ready_busy", {31'd0, bus.cmd_ready}, 32'd0);
      tick();
    end
    chk("done_pulse", {31'd0, bus.done}, 32'd1);
    chk("busy_at_done", {31'd0, bus.busy}, 32'd0);
    chk("ab_at_done", {30'd0, bus.a, bus.b}, 32'd0);
    chk("ready_at_done", {31'd0, bus.cmd_ready}, 32'd1);
  endtask

  task automatic send(input logic [1:0] c, input logic [1:0] p1, input logic [1:0] p3);
    bus.cmd_valid = 1'b1;
    bus.cmd       = c;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd       = 2'b11;
    check_wave(p1, p3);
  endtask

  task automatic chk_tallies(input string tag);
    chk({tag, "_enters"}, {24'd0, bus.enters_sent}, 32'(exp_en % 256));
    chk({tag, "_exits"}, {24'd0, bus.exits_sent}, 32'(exp_ex % 256));
  endtask

  initial begin
    rst            = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd        = 2'b00;
    bus2.cmd_valid = 1'b0;
    bus2.cmd       = 2'b00;
    repeat (2) tick();
    chk("rst_ab", {30'd0, bus.a, bus.b}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_ready", {31'd0, bus.cmd_ready}, 32'd0);
    chk_tallies("rst");
    rst = 1'b0;
    #1;
    chk("ready_after_rst", {31'd0, bus.cmd_ready}, 32'd1);

    // cmd ignored without cmd_valid
    bus.cmd = 2'b00;
    repeat (3) tick();
    chk("novalid_busy", {31'd0, bus.busy}, 32'd0);
    chk("novalid_ab", {30'd0, bus.a, bus.b}, 32'd0);

    // Reset during PH2 of an enter
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    repeat (5) tick();
    chk("mid_ph2_ab", {30'd0, bus.a, bus.b}, 32'd3);
    rst = 1'b1;
    #1;
    chk("mid_rst_ab", {30'd0, bus.a, bus.b}, 32'd0);
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      chk("mid_rst_nodone", {31'd0, bus.done}, 32'd0);
      tick();
    end
    chk_tallies("mid_rst");

    send(2'b00, 2'b10, 2'b01);
    exp_en++;
    chk_tallies("enter");
    tick();
    chk("idle_after_done", {31'd0, bus.done}, 32'd0);

    send(2'b01, 2'b01, 2'b10);
    exp_ex++;
    chk_tallies("exit");

    send(2'b10, 2'b10, 2'b10);
    chk_tallies("balk_enter");
    send(2'b11, 2'b01, 2'b01);
    chk_tallies("balk_exit");
    tick();

    // Held cmd_valid: next acceptance lands on each done cycle
    bus.cmd_valid = 1'b1;
    bus.cmd       = 2'b00;
    tick();
    for (int s = 0; s < 3; s++) begin
      check_wave(2'b10, 2'b01);
      exp_en++;
      chk_tallies("b2b");
      if (s == 2) bus.cmd_valid = 1'b0;
      tick();
    end
    chk("b2b_idle_busy", {31'd0, bus.busy}, 32'd0);
    chk("b2b_idle_ab", {30'd0, bus.a, bus.b}, 32'd0);

    // Narrow instance: DWELL=1, GAP=1, 2-bit tallies wrap
    bus2.cmd_valid = 1'b1;
    bus2.cmd       = 2'b00;
    tick();
    for (int i = 0; i < 5; i++) begin
      repeat (4) tick();
      chk("wrap_done", {31'd0, bus2.done}, 32'd1);
      chk("wrap_enters", {30'd0, bus2.enters_sent}, 32'((i + 1) % 4));
      chk("wrap_exits", {30'd0, bus2.exits_sent}, 32'd0);
      if (i == 4) bus2.cmd_valid = 1'b0;
      tick();
    end
    chk("wrap_idle", {31'd0, bus2.busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sensor_seq_gen.md
Name: sensor_seq_gen

Overview:
- Transmitter-side model of the gate sensor pair: converts a command (car enters, car exits, car balks) into timed two-beam sensor waveforms on a/b.
- Output pattern is what the debounce + parking FSM receive chain expects at its inputs.
- Used as stimulus source in board-level self-test and in the lot-counter regression benches.
- Also keeps a running tally of complete enters/exits sent, so the displayed lot count can be checked against it.

Parameters:
- DWELL_CYCLES, 4, clock cycles each sensor phase is held; legal range ≥1. For real debounce use, set it above the debounce settle time.
- GAP_CYCLES, 3, cycles both beams are held clear after the last phase, before done; legal range ≥1.
- CNT_W, 8, width of the enter/exit tallies.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd  in  2  00 enter, 01 exit, 10 balk_enter, 11 balk_exit
- cmd_ready  out  1  block idle and able to accept a command
- a  out  1  outer beam sensor (1 = blocked)
- b  out  1  inner beam sensor (1 = blocked)
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse when a sequence completes
- enters_sent  out  CNT_W  count of completed enter sequences, wrapping
- exits_sent  out  CNT_W  count of completed exit sequences, wrapping

Behaviour:
- All outputs are registered. Reset values: a=0, b=0, busy=0, done=0, enters_sent=0, exits_sent=0, state=IDLE.
- cmd_ready = (state==IDLE) && !reset. It is combinational from state.
- States:
  - IDLE: ab=00. On cmd_valid && cmd_ready at clock edge k, latch cmd, go to PH1, busy=1 from edge k. cmd is ignored when cmd_valid=0.
  - PH1, PH2, PH3: ab holds the phase pattern for exactly DWELL_CYCLES cycles each, then advances.
  - GAP: ab=00 for exactly GAP_CYCLES cycles.
  - After GAP: return to IDLE with done=1 for one cycle, busy=0 in that same cycle, and tally update in that same cycle.
- Patterns {a,b} for PH1/PH2/PH3:
  - enter: 10/11/01
  - exit: 01/11/10
  - balk_enter: 10/11/10
  - balk_exit: 01/11/01
- The new pattern appears on the same edge that accepts the command or ends the previous phase. There are no glitches and never a 00 between PH1 and PH3.
- Sequence length from acceptance edge to the done edge = 3*DWELL_CYCLES + GAP_CYCLES cycles.
- Back-to-back commands: the earliest next acceptance is the cycle where done=1, because cmd_ready is back at 1 there.
- A cmd_valid held while busy is neither lost nor acknowledged; it is accepted once IDLE.
- Tallies:
  - enters_sent increments only on completion of an enter.
  - exits_sent increments only on completion of an exit.
  - Balks change neither tally.
  - Both tallies wrap from 2^CNT_W-1 to 0.
- Reset mid-sequence: a and b go to 0 immediately (asynchronously), the state goes to IDLE, no done pulse, and the in-flight command is not counted.
- Dwell counter: width $clog2(max(DWELL_CYCLES,GAP_CYCLES)+1). It is loaded on each phase entry and counts down to 1. It never underflows.

Decomposition:
- Shared package sensor_seq_pkg holds:
  - cmd encodings CMD_ENTER, CMD_EXIT, CMD_BALK_ENTER, CMD_BALK_EXIT
  - state enum IDLE/PH1/PH2/PH3/GAP
  - pattern constants per command and phase
- One natural sub-module: dwell_timer. It takes a load pulse and a load value, and gives an expiry flag. It is reused for the phase timing and the gap timing.

Test Plan:
- Reset, then cmd=00 with DWELL=4, GAP=3 → ab = 10 for 4 cycles, 11 for 4, 01 for 4, 00 for 3; done pulses at cycle 15 after acceptance; enters_sent=1, exits_sent=0.
- cmd=01 → ab = 01, 11, 10, 00 with the same timing; exits_sent=1. Through the debounce+FSM+counter chain, the lot display shows 0 after enter then exit.
- cmd=10 then cmd=11 → ab never reaches the opposite-only pattern; both tallies stay unchanged; the downstream lot count is unchanged.
- cmd_valid held high with cmd=00 for 3 sequences → acceptances happen exactly on the done cycles; no idle gap beyond GAP; enters_sent=3.
- Assert reset during PH2 of an enter → a=b=0 immediately; busy=0; no done pulse; enters_sent stays at its prior value; the next command runs normally.
- CNT_W=2, 5 enters → enters_sent sequence 1,2,3,0,1.
